// File: rtl/pi_spi_master.sv
// pi_spi_master: SPI mode-0 master that issues PI-bus frames (4-byte header, then len data bytes).
// Define PI_MST_DUMMY_EN to insert one all-ones turnaround byte after the header on reads with len>0.
module pi_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        rd,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        spi_ss,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int MAXC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_HDR,
`ifdef PI_MST_DUMMY_EN
    S_DUMMY,
`endif
    S_DWAIT,
    S_DATA,
    S_FINISH,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] sh_q, sh_d;
  logic [7:0]  rxsh_q, rxsh_d;
  logic [15:0] bytes_q, bytes_d;
  logic        rd_q, rd_d;
  logic        ss_q, ss_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_pend_q, rx_pend_d;
  logic        tick;
  logic        in_shift;

  assign tick = (cnt_q == DIV_LAST);

`ifdef PI_MST_DUMMY_EN
  assign in_shift = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_DUMMY);
`else
  assign in_shift = (state_q == S_HDR) || (state_q == S_DATA);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rxsh_d     = rxsh_q;
    bytes_d    = bytes_q;
    rd_d       = rd_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_pend_d  = 1'b0;
    tx_ready   = 1'b0;

    // rx_pend marks the edge that captured the 8th data bit; publish one cycle later
    if (rx_pend_q) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rxsh_q;
    end

    if (in_shift) begin
      if (!tick) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        sck_d = ~sck_q;
        if (!sck_q) begin
          rxsh_d = {rxsh_q[6:0], spi_miso};
          if (state_q == S_DATA && rd_q && bit_q == 5'd0) rx_pend_d = 1'b1;
        end else if (bit_q != 5'd0) begin
          bit_d  = bit_q - 1'b1;
          sh_d   = sh_q << 1;
          mosi_d = sh_q[30];
        end else begin
          mosi_d = 1'b0;
          bit_d  = 5'd7;
          if (state_q == S_HDR) begin
            if (bytes_q == 16'd0) begin
              state_d = S_FINISH;
            end
`ifdef PI_MST_DUMMY_EN
            else if (rd_q) begin
              state_d = S_DUMMY;
              sh_d    = '1;
              mosi_d  = 1'b1;
            end
`endif
            else begin
              state_d = S_DWAIT;
            end
          end else if (state_q == S_DATA) begin
            bytes_d = bytes_q - 16'd1;
            state_d = (bytes_q == 16'd1) ? S_FINISH : S_DWAIT;
          end else begin
            state_d = S_DWAIT;
          end
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_d    = rd;
            bytes_d = len;
            sh_d    = {cmd, addr};
            mosi_d  = cmd[7];
            ss_d    = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            bit_d   = 5'd31;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) begin
            cnt_d   = '0;
            state_d = S_HDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DWAIT: begin
          if (rd_q) begin
            sh_d    = '0;
            mosi_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = 5'd7;
            state_d = S_DATA;
          end else if (tx_valid) begin
            tx_ready = 1'b1;
            sh_d     = {tx_data, 24'h0};
            mosi_d   = tx_data[7];
            cnt_d    = '0;
            bit_d    = 5'd7;
            state_d  = S_DATA;
          end
        end
        S_FINISH: begin
          if (tick) begin
            ss_d    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rxsh_q     <= '0;
      bytes_q    <= '0;
      rd_q       <= 1'b0;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rxsh_q     <= rxsh_d;
      bytes_q    <= bytes_d;
      rd_q       <= rd_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_pend_q  <= rx_pend_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_ss   = ss_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_pi_spi_master.sv
// Bench for pi_spi_master: SPI slave model on the wire, per-cycle rule checks, directed frames.
module tb_pi_spi_master;
  localparam int CD  = 2;
  localparam int GAP = 4;
`ifdef PI_MST_DUMMY_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  cmd = '0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        spi_miso = 1'b0;
  logic        busy, done, tx_ready, rx_valid, spi_ss, spi_sck, spi_mosi;
  logic [7:0]  rx_data;

  pi_spi_master #(.CLK_DIV(CD), .GAP_CYC(GAP)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .rd(rd), .cmd(cmd), .addr(addr), .len(len),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .spi_ss(spi_ss), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Frame model state
  bit         mon_en = 1'b0;
  bit         cur_rd;
  int         cur_len, hdr_rises;
  int         rises, ss_low, n_done, n_txr, n_rxv, rx_cnt, tx_cnt, wait_cyc, high_run;
  logic       prev_sck = 1'b0;
  logic       mosi_at_rise;
  bit         rx_due;
  bit         mbits[$];
  bit         miso_bits[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] txq[$];
  int         stall_idx = -1;
  int         stall_n = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rxv, waiting;
      if (!spi_ss) ss_low++;
      if (spi_ss) chk("sck_idle_low", spi_sck, 0);
      exp_rxv = rx_due;
      rx_due = 1'b0;
      if (spi_sck && !prev_sck) begin
        rises++;
        mbits.push_back(spi_mosi);
        mosi_at_rise = spi_mosi;
        high_run = 1;
        if (cur_rd && rises > hdr_rises && ((rises - hdr_rises) % 8) == 0) rx_due = 1'b1;
      end else if (spi_sck) begin
        high_run++;
        chk("mosi_stable_high", spi_mosi, mosi_at_rise);
      end else if (prev_sck) begin
        chk("sck_high_len", high_run, CD);
      end
      chk("rx_valid", rx_valid, exp_rxv);
      if (rx_valid) begin
        n_rxv++;
        if (rx_cnt < exp_rx.size()) chk("rx_data", rx_data, exp_rx[rx_cnt]);
        rx_cnt++;
      end
      waiting = !cur_rd && !spi_ss && !spi_sck && (rises == 32 + 8 * tx_cnt) && (tx_cnt < cur_len);
      chk("tx_ready", tx_ready, waiting && tx_valid);
      if (waiting && !tx_valid) wait_cyc++;
      if (tx_ready) begin
        n_txr++;
        tx_cnt++;
      end
      if (done) begin
        n_done++;
        chk("done_ss_high", spi_ss, 1);
        chk("done_busy_low", busy, 0);
      end
      prev_sck = spi_sck;
      spi_miso = (rises < miso_bits.size()) ? miso_bits[rises] : 1'b0;
    end
  end

  // Write-data source; optionally withholds one byte for stall_n waiting cycles
  always @(posedge clk) begin
    #1;
    if (tx_cnt < txq.size() && !(tx_cnt == stall_idx && wait_cyc < stall_n)) begin
      tx_valid = 1'b1;
      tx_data  = txq[tx_cnt];
    end else begin
      tx_valid = 1'b0;
    end
  end

  task automatic push_miso(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) miso_bits.push_back(b[i]);
  endtask

  task automatic begin_frame(input bit r, input logic [15:0] l);
    cur_rd = r; cur_len = int'(l);
    hdr_rises = 32 + ((DUMMY && r && l != 0) ? 8 : 0);
    rises = 0; ss_low = 0; n_done = 0; n_txr = 0; n_rxv = 0; rx_cnt = 0; tx_cnt = 0;
    wait_cyc = 0; high_run = 0; prev_sck = 1'b0; rx_due = 1'b0;
    mbits.delete();
    mon_en = 1'b1;
  endtask

  task automatic run(input bit r, input logic [7:0] c, input logic [23:0] a, input logic [15:0] l);
    int k;
    repeat (GAP + 2) @(posedge clk);
    begin_frame(r, l);
    #1;
    rd = r; cmd = c; addr = a; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rd = ~r; cmd = ~c; addr = ~a; len = 16'hBEEF;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("ss_after_start", spi_ss, 0);
    k = 0;
    while (n_done == 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 5000) chk("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_nbits"}, rises, exp_mosi.size() * 8);
    for (int i = 0; i < exp_mosi.size(); i++) begin
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 8; j++)
        if (i * 8 + j < mbits.size()) b[7 - j] = mbits[i * 8 + j];
      chk({nm, "_mosi_byte"}, b, exp_mosi[i]);
    end
    chk({nm, "_done_cnt"}, n_done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dn;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_ss", spi_ss, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);

    // 1: write len=2
    miso_bits.delete(); exp_rx.delete();
    txq = '{8'h11, 8'h22};
    exp_mosi = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h11, 8'h22};
    run(1'b0, 8'hA5, 24'h123456, 16'd2);
    check_frame("wr2");
    chk("wr2_rises", rises, 48);
    chk("wr2_tx_ready_cnt", n_txr, 2);

    // 2: read len=3
    txq.delete(); miso_bits.delete();
    for (int i = 0; i < 4; i++) push_miso(8'h00);
    if (DUMMY) push_miso(8'hAA);
    push_miso(8'hC3); push_miso(8'h00); push_miso(8'hFF);
    exp_rx = '{8'hC3, 8'h00, 8'hFF};
    exp_mosi = '{8'h03, 8'h00, 8'h01, 8'h00};
    if (DUMMY) exp_mosi.push_back(8'hFF);
    for (int i = 0; i < 3; i++) exp_mosi.push_back(8'h00);
    run(1'b1, 8'h03, 24'h000100, 16'd3);
    check_frame("rd3");
    chk("rd3_rises", rises, DUMMY ? 64 : 56);
    chk("rd3_rx_valid_cnt", n_rxv, 3);
    chk("rd3_tx_ready_cnt", n_txr, 0);

    // 3: header-only write, then a start during GAP must be ignored
    miso_bits.delete(); exp_rx.delete(); txq.delete();
    exp_mosi = '{8'h5A, 8'hAB, 8'hCD, 8'hEF};
    run(1'b0, 8'h5A, 24'hABCDEF, 16'd0);
    check_frame("len0");
    chk("len0_rises", rises, 32);
    chk("len0_ss_low_cycles", ss_low, 132);
    chk("len0_tx_ready_cnt", n_txr, 0);
    #1 start = 1'b1; rd = 1'b0; cmd = 8'h77; len = 16'd0;
    @(posedge clk); #1 start = 1'b0;
    ss_low = 0;
    repeat (12) @(posedge clk);
    chk("gap_start_ignored_ss", ss_low, 0);
    chk("gap_start_ignored_busy", busy, 0);

    // 4: write with byte 2 withheld for 50 waiting cycles
    txq = '{8'h5E, 8'hC7};
    stall_idx = 1; stall_n = 50;
    exp_mosi = '{8'h80, 8'h00, 8'h00, 8'h10, 8'h5E, 8'hC7};
    run(1'b0, 8'h80, 24'h000010, 16'd2);
    check_frame("stall");
    chk("stall_wait_cycles", wait_cyc, 50);
    chk("stall_tx_ready_cnt", n_txr, 2);
    stall_idx = -1; stall_n = 0;

    // 5: reset during header bit 10, then a fresh frame
    txq.delete();
    repeat (GAP + 2) @(posedge clk);
    begin_frame(1'b0, 16'd1);
    #1 rd = 1'b0; cmd = 8'hF0; addr = 24'h0F0F0F; len = 16'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (rises < 22 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 1000) chk("rst_mid_timeout", 0, 1);
    #1 sys_rst = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1 sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ss", spi_ss, 1);
    chk("rst_mid_sck", spi_sck, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mosi", spi_mosi, 0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("rst_mid_no_done", dn, 0);
    txq = '{8'h3C};
    exp_mosi = '{8'h96, 8'h00, 8'h00, 8'h01, 8'h3C};
    run(1'b0, 8'h96, 24'h000001, 16'd1);
    check_frame("after_rst");
    chk("after_rst_rises", rises, 40);

`ifdef PI_MST_DUMMY_EN
    // 6: read len=1 with turnaround byte
    txq.delete(); miso_bits.delete();
    for (int i = 0; i < 4; i++) push_miso(8'h00);
    push_miso(8'hAA); push_miso(8'h96);
    exp_rx = '{8'h96};
    exp_mosi = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h00};
    run(1'b1, 8'h0B, 24'h000010, 16'd1);
    check_frame("dummy");
    chk("dummy_rises", rises, 48);
    chk("dummy_rx_valid_cnt", n_rxv, 1);
`endif

    repeat (GAP + 2) @(posedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
